run_gen: RTL
============

# run_gen

Stimulus generator for the run detector. On a start request it issues the capture pulse with a threshold sample. It then drives a programmed number of runs, each a fixed number of consecutive samples strictly above threshold, with below-or-equal gaps between them. It also keeps the count the detector is expected to report, so the pair can be closed-loop self-checked on the same clock.

## Interface
- DET_LEN, 4, minimum run length (consecutive above-threshold samples) that the detector counts as one event
- TAIL, 2, below-threshold cycles driven after the last run, before done
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a sequence; sampled only in IDLE
- thresh  in  4  threshold value; latched on accepted start
- run_len  in  4  samples per run; latched; 0 treated as 1
- gap_len  in  4  below-threshold samples between runs; latched; 0 treated as 1
- num_runs  in  4  runs to emit; latched
- sig  out  4  sample stream to the detector
- strtCapCmp  out  1  capture pulse to the detector; one cycle
- busy  out  1  high from CAP through TAIL
- done  out  1  one-cycle pulse at sequence end
- err  out  1  one-cycle pulse on an unsatisfiable request
- exp_abv  out  4  expected detector count, saturating at 15

## Operation
- States: IDLE, CAP, RUN, GAP, TAIL, DONE.
- IDLE
  - Outputs idle: sig=0, strtCapCmp=0, busy=0.
  - start=1 latches thresh/run_len/gap_len/num_runs and clears exp_abv and the runs-sent counter.
  - If latched thresh==4'hF and num_runs!=0: go to DONE with err=1 (no above value exists); no CAP is issued.
  - Otherwise go to CAP.
- CAP (1 cycle)
  - strtCapCmp=1, sig=thresh.
  - Next state RUN if num_runs!=0, else TAIL.
- RUN
  - Drives an above value for run_len cycles, using an in-run counter.
  - On the last cycle, increment runs_sent.
  - If run_len>=DET_LEN, increment exp_abv (saturating).
  - Next state GAP if runs_sent+1<num_runs, else TAIL.
- GAP: drives a below value for gap_len cycles, then RUN.
- TAIL: drives a below value for TAIL cycles, then DONE.
- DONE (1 cycle)
  - done=1, err as set, busy=0, sig=0; then IDLE.
- Value rules (default build)
  - Above value = thresh+1.
  - Below value = thresh; equality counts as not above.
- Boundaries
  - start while not IDLE is ignored. Input changes while busy are ignored.
  - start asserted during the DONE cycle is ignored. start held high re-triggers from IDLE on the cycle after DONE.
  - num_runs=0: CAP, TAIL, DONE; exp_abv=0.
  - run_len<DET_LEN: runs are emitted but exp_abv is not incremented.
  - exp_abv saturates at 4'hF and does not wrap.
- rst at any point: next edge forces IDLE and all outputs to reset values; any in-flight sequence is abandoned.

## Timing
- Reset values: sig=0, strtCapCmp=0, busy=0, done=0, err=0, exp_abv=0.
- All outputs are registered.
- start sampled high at edge N (in IDLE): strtCapCmp=1 and busy=1 during cycle N+1.
- First RUN sample appears in cycle N+2.
- Total busy cycles = 1 + num_runs*run_len + (num_runs-1)*gap_len + TAIL, for num_runs>0.
- done is high in the cycle immediately after the last TAIL cycle.
- exp_abv updates at the edge ending each qualifying run. It is stable by DONE and holds until the next accepted start.
- Error path: err and done are both high in cycle N+1; busy stays 0.

## Configuration
- RUN_GEN_LFSR_EN defined: a 4-bit LFSR (x^4+x^3+1, seed 4'h9) advances every non-IDLE cycle.
  - Above value = lfsr>thresh ? lfsr : 4'hF.
  - Below value = lfsr<=thresh ? lfsr : thresh.
  - The LFSR resets to seed on rst and on accepted start. State sequencing and timing are unchanged.
- Not defined: deterministic values thresh+1 / thresh; no LFSR logic is present.

## Test plan
- rst high 2 cycles mid-RUN, then low → all outputs 0 next cycle, state IDLE, exp_abv=0.
- thresh=5, run_len=4, gap_len=1, num_runs=3 → strtCapCmp one cycle with sig=5; sig runs 6,6,6,6 separated by single 5s; busy 17 cycles; done pulse; exp_abv=3.
- thresh=5, run_len=3, num_runs=2 → runs emitted, exp_abv=0.
- thresh=4'hF, num_runs=1 → err=1 and done=1 one cycle after start; strtCapCmp never asserted.
- num_runs=0, thresh=2 → CAP, 2 TAIL cycles of sig=2, done; exp_abv=0. start pulsed while busy is ignored.
- Connect to the run detector with RUN_GEN_LFSR_EN, thresh=7, run_len=5, gap_len=2, num_runs=6 → at done, detector N_abv == exp_abv == 6.

Source files
------------

// File: rtl/run_gen.sv
// run_gen: stimulus generator for the run detector.
// Issues a capture pulse carrying the threshold, then a programmed number of
// above-threshold runs separated by below-or-equal gaps, then a short tail.
// Tracks the event count the detector should report (exp_abv).
// Optional build macro RUN_GEN_LFSR_EN: sample values come from a 4-bit LFSR
// instead of the deterministic thresh+1 / thresh pair.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | outputs quiet, waiting for start
// CAP    | capture pulse, sig carries the threshold
// RUN    | above-threshold samples for run_len cycles
// GAP    | below-or-equal samples for gap_len cycles
// TAIL   | below-or-equal samples for TAIL cycles after the last run
// DONE   | done pulse (err also set on an unsatisfiable request)
module run_gen #(
  parameter int DET_LEN = 4,
  parameter int TAIL    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] thresh,
  input  logic [3:0] run_len,
  input  logic [3:0] gap_len,
  input  logic [3:0] num_runs,
  output logic [3:0] sig,
  output logic       strtCapCmp,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] exp_abv
);

  typedef enum logic [2:0] {
    S_IDLE, S_CAP, S_RUN, S_GAP, S_TAIL, S_DONE
  } state_t;

  localparam logic [4:0] DET_LEN_C = 5'(DET_LEN);
  localparam logic [3:0] TAIL_M1   = 4'(TAIL - 1);

  state_t     state_q;
  logic [3:0] thresh_q, rl_q, gl_q, nr_q;
  logic [3:0] runs_q, cnt_q;
  logic [3:0] sig_q, abv_q;
  logic       strt_q, busy_q, done_q, err_q;
  logic [3:0] above_d, below_d;
  logic       more_runs_d, qualify_d;

`ifdef RUN_GEN_LFSR_EN
  localparam logic [3:0] LFSR_SEED = 4'h9;
  logic [3:0] lfsr_q, lfsr_d;

  // x^4+x^3+1 Fibonacci step
  assign lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};

  // LFSR reseeds on accepted start and free-runs while a sequence is active
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (state_q == S_IDLE) begin
      if (start) lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // pseudo-random sample values that still respect the threshold relation
  always_comb begin
    above_d = (lfsr_q > thresh_q) ? lfsr_q : 4'hF;
    below_d = (lfsr_q <= thresh_q) ? lfsr_q : thresh_q;
  end
`else
  // deterministic sample values; equality with thresh counts as not above
  always_comb begin
    above_d = 4'(thresh_q + 4'd1);
    below_d = thresh_q;
  end
`endif

  // run-bookkeeping decisions taken on the last cycle of a run
  always_comb begin
    more_runs_d = (({1'b0, runs_q} + 5'd1) < {1'b0, nr_q});
    qualify_d   = ({1'b0, rl_q} >= DET_LEN_C);
  end

  // sequencing FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      thresh_q <= '0;
      rl_q     <= '0;
      gl_q     <= '0;
      nr_q     <= '0;
      runs_q   <= '0;
      cnt_q    <= '0;
      sig_q    <= '0;
      abv_q    <= '0;
      strt_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      strt_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          sig_q  <= '0;
          busy_q <= 1'b0;
          if (start) begin
            thresh_q <= thresh;
            rl_q     <= (run_len == 4'd0) ? 4'd1 : run_len;
            gl_q     <= (gap_len == 4'd0) ? 4'd1 : gap_len;
            nr_q     <= num_runs;
            runs_q   <= '0;
            abv_q    <= '0;
            if (thresh == 4'hF && num_runs != 4'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_CAP;
              strt_q  <= 1'b1;
              busy_q  <= 1'b1;
              sig_q   <= thresh;
            end
          end
        end
        S_CAP: begin
          if (nr_q != 4'd0) begin
            state_q <= S_RUN;
            cnt_q   <= rl_q - 4'd1;
            sig_q   <= above_d;
          end else begin
            state_q <= S_TAIL;
            cnt_q   <= TAIL_M1;
            sig_q   <= below_d;
          end
        end
        S_RUN: begin
          if (cnt_q == 4'd0) begin
            runs_q <= runs_q + 4'd1;
            if (qualify_d && abv_q != 4'hF) abv_q <= abv_q + 4'd1;
            sig_q <= below_d;
            if (more_runs_d) begin
              state_q <= S_GAP;
              cnt_q   <= gl_q - 4'd1;
            end else begin
              state_q <= S_TAIL;
              cnt_q   <= TAIL_M1;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
            sig_q <= above_d;
          end
        end
        S_GAP: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_RUN;
            cnt_q   <= rl_q - 4'd1;
            sig_q   <= above_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            sig_q <= below_d;
          end
        end
        S_TAIL: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            sig_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            sig_q <= below_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          sig_q   <= '0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sig        = sig_q;
  assign strtCapCmp = strt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign exp_abv    = abv_q;

endmodule
